// File: rtl/cmsdk_apb_multitimer_pkg.sv
// Shared constants for the APB multi-channel timer.
// Register offsets, CTRL bit positions and peripheral ID bytes.
package cmsdk_apb_multitimer_pkg;

   localparam logic [2:0] REG_LOAD   = 3'd0;
   localparam logic [2:0] REG_VALUE  = 3'd1;
   localparam logic [2:0] REG_CTRL   = 3'd2;
   localparam logic [2:0] REG_INTCLR = 3'd3;
   localparam logic [2:0] REG_RIS    = 3'd4;
   localparam logic [2:0] REG_MIS    = 3'd5;
   localparam logic [2:0] REG_BGLOAD = 3'd6;

   localparam logic [9:0] ADDR_INTSTAT = 10'h040;
   localparam logic [9:0] ADDR_ITCR    = 10'h3C0;
   localparam logic [9:0] ADDR_ITOP    = 10'h3C1;
   localparam logic [5:0] ADDR_ID_BLK  = 6'h3F;

   localparam int CTRL_ONESHOT  = 0;
   localparam int CTRL_CHAIN    = 1;
   localparam int CTRL_PERIODIC = 5;
   localparam int CTRL_INTEN    = 6;
   localparam int CTRL_ENABLE   = 7;
   localparam int CTRL_PRE_LSB  = 8;

   localparam logic [15:0] CTRL_RST  = 16'h0040;
   localparam logic [15:0] CTRL_MASK = 16'hFFE3;

   // ID byte for word index 4..15 of the 0xFC0 block.
   function automatic logic [7:0] id_byte(
      input logic [3:0] idx,
      input logic [3:0] eco
   );
      logic [7:0] b;
      b = 8'h00;
      case (idx)
         4'd4:    b = 8'h04;
         4'd8:    b = 8'h24;
         4'd9:    b = 8'hB8;
         4'd10:   b = 8'h1B;
         4'd11:   b = {eco, 4'h0};
         4'd12:   b = 8'h0D;
         4'd13:   b = 8'hF0;
         4'd14:   b = 8'h05;
         4'd15:   b = 8'hB1;
         default: b = 8'h00;
      endcase
      return b;
   endfunction

endpackage

// File: rtl/cmsdk_apb_multitimer_ch.sv
// One timer channel: prescaler, down-counter, raw interrupt,
// CTRL/LOAD registers and the zero-event used for cascading.
module cmsdk_apb_multitimer_ch
   import cmsdk_apb_multitimer_pkg::*;
#(
   parameter int CNT_WIDTH = 32,
   parameter bit HAS_PREV  = 1'b0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 wr_en,
   input  logic [2:0]           wr_reg,
   input  logic [31:0]          wdata,
   input  logic                 timclken,
   input  logic                 chain_in,
   output logic [CNT_WIDTH-1:0] value,
   output logic [CNT_WIDTH-1:0] load,
   output logic [15:0]          ctrl,
   output logic                 ris,
   output logic                 zero_evt
);

   logic [CNT_WIDTH-1:0] value_q, value_d;
   logic [CNT_WIDTH-1:0] load_q, load_d;
   logic [15:0]          ctrl_q, ctrl_d;
   logic [7:0]           pre_q, pre_d;
   logic                 ris_q, ris_d;
   logic                 zpend_q, zpend_d;

   logic wr_load, wr_ctrl, wr_intclr, wr_bgload;
   logic en_eff, src, pulse, tick, evt;

   // Write decode, tick generation and next-state for all channel state.
   always_comb begin
      wr_load   = wr_en & (wr_reg == REG_LOAD);
      wr_ctrl   = wr_en & (wr_reg == REG_CTRL);
      wr_intclr = wr_en & (wr_reg == REG_INTCLR);
      wr_bgload = wr_en & (wr_reg == REG_BGLOAD);

      // Clearing ENABLE wins over a tick in the same cycle.
      en_eff = ctrl_q[CTRL_ENABLE]
             & ~(wr_ctrl & ~wdata[CTRL_ENABLE]);
      src    = (HAS_PREV && ctrl_q[CTRL_CHAIN]) ? chain_in
                                                : timclken;
      pulse  = src & en_eff;
      tick   = pulse & (pre_q == 8'd0) & ~wr_load;

      ctrl_d = ctrl_q;
      if (wr_ctrl)
         ctrl_d = wdata[15:0] & CTRL_MASK;

      load_d = load_q;
      if (wr_load | wr_bgload)
         load_d = wdata[CNT_WIDTH-1:0];

      pre_d = pre_q;
      if (wr_load)
         pre_d = 8'd0;
      else if (pulse)
         pre_d = (pre_q == 8'd0) ? ctrl_q[CTRL_PRE_LSB +: 8]
                                 : pre_q - 8'd1;

      evt = tick & ((value_q == CNT_WIDTH'(1)) | zpend_q);

      value_d = value_q;
      if (wr_load)
         value_d = wdata[CNT_WIDTH-1:0];
      else if (tick) begin
         if (value_q == CNT_WIDTH'(1))
            value_d = '0;
         else if (value_q == '0) begin
            if (ctrl_q[CTRL_ONESHOT])
               value_d = '0;
            else if (ctrl_q[CTRL_PERIODIC])
               value_d = load_d;
            else
               value_d = '1;
         end else
            value_d = value_q - CNT_WIDTH'(1);
      end

      // A LOAD of zero raises the interrupt on the next tick.
      zpend_d = zpend_q;
      if (wr_load)
         zpend_d = (wdata[CNT_WIDTH-1:0] == '0);
      else if (tick)
         zpend_d = 1'b0;

      ris_d = ris_q;
      if (evt)
         ris_d = 1'b1;
      else if (wr_intclr)
         ris_d = 1'b0;
   end

   // Channel state registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         value_q <= '1;
         load_q  <= '0;
         ctrl_q  <= CTRL_RST;
         pre_q   <= 8'd0;
         ris_q   <= 1'b0;
         zpend_q <= 1'b0;
      end else begin
         value_q <= value_d;
         load_q  <= load_d;
         ctrl_q  <= ctrl_d;
         pre_q   <= pre_d;
         ris_q   <= ris_d;
         zpend_q <= zpend_d;
      end
   end

   assign value    = value_q;
   assign load     = load_q;
   assign ctrl     = ctrl_q;
   assign ris      = ris_q;
   assign zero_evt = evt;

endmodule

// File: rtl/cmsdk_apb_multitimer.sv
// APB multi-channel timer top: decode, read mux, chain wiring.
// CMSDK_MULTITIMER_ITEST_EN adds the ITCR/ITOP test registers.
module cmsdk_apb_multitimer
   import cmsdk_apb_multitimer_pkg::*;
#(
   parameter int NUM_CH    = 2,
   parameter int CNT_WIDTH = 32
) (
   input  logic              PCLK,
   input  logic              PRESET,
   input  logic              PSEL,
   input  logic              PENABLE,
   input  logic              PWRITE,
   input  logic [11:2]       PADDR,
   input  logic [31:0]       PWDATA,
   input  logic [NUM_CH-1:0] TIMCLKEN,
   input  logic [3:0]        ECOREVNUM,
   output logic [31:0]       PRDATA,
   output logic [NUM_CH-1:0] TIMINT,
   output logic              TIMINTC
);

   logic setup_wr, setup_rd, ch_space, id_hit;
   logic [2:0] ch_idx, reg_idx;

   logic [NUM_CH-1:0] zero_evt, ris, inten, mis;
   logic [NUM_CH-1:0] chain_src, ch_wr;
   logic [CNT_WIDTH-1:0] ch_value [NUM_CH];
   logic [CNT_WIDTH-1:0] ch_load  [NUM_CH];
   logic [15:0]          ch_ctrl  [NUM_CH];

   logic [31:0] rd_mux;
   logic [31:0] prdata_q, prdata_d;

   assign setup_wr = PSEL & PWRITE & ~PENABLE;
   assign setup_rd = PSEL & ~PWRITE & ~PENABLE;
   assign ch_idx   = PADDR[7:5];
   assign reg_idx  = PADDR[4:2];
   assign ch_space = (PADDR[11:8] == 4'h0)
                   & ({1'b0, ch_idx} < 4'(NUM_CH));
   assign id_hit   = (PADDR[11:6] == ADDR_ID_BLK)
                   & (PADDR[5:2] >= 4'h4);

   for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
      if (n == 0) begin : g_first
         assign chain_src[n] = 1'b0;
      end else begin : g_next
         assign chain_src[n] = zero_evt[n-1];
      end

      assign ch_wr[n] = setup_wr & ch_space & (ch_idx == 3'(n));
      assign inten[n] = ch_ctrl[n][CTRL_INTEN];

      cmsdk_apb_multitimer_ch #(
         .CNT_WIDTH (CNT_WIDTH),
         .HAS_PREV  (n != 0)
      ) u_ch (
         .clk      (PCLK),
         .rst      (PRESET),
         .wr_en    (ch_wr[n]),
         .wr_reg   (reg_idx),
         .wdata    (PWDATA),
         .timclken (TIMCLKEN[n]),
         .chain_in (chain_src[n]),
         .value    (ch_value[n]),
         .load     (ch_load[n]),
         .ctrl     (ch_ctrl[n]),
         .ris      (ris[n]),
         .zero_evt (zero_evt[n])
      );
   end

   assign mis = ris & inten;

`ifdef CMSDK_MULTITIMER_ITEST_EN
   logic              itcr_q, itcr_d;
   logic [NUM_CH-1:0] itop_q, itop_d;

   // Integration test control and output override registers.
   always_comb begin
      itcr_d = itcr_q;
      itop_d = itop_q;
      if (setup_wr && PADDR == ADDR_ITCR)
         itcr_d = PWDATA[0];
      if (setup_wr && PADDR == ADDR_ITOP)
         itop_d = PWDATA[NUM_CH-1:0];
   end

   // Integration test register state.
   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         itcr_q <= 1'b0;
         itop_q <= '0;
      end else begin
         itcr_q <= itcr_d;
         itop_q <= itop_d;
      end
   end

   assign TIMINT = itcr_q ? itop_q : mis;
`else
   assign TIMINT = mis;
`endif

   assign TIMINTC = |TIMINT;

   // Setup-phase read mux; PRDATA is zero outside read accesses.
   always_comb begin
      rd_mux = 32'h0;
      unique case (1'b1)
         ch_space: begin
            for (int n = 0; n < NUM_CH; n++) begin
               if (ch_idx == 3'(n)) begin
                  unique case (reg_idx)
                     REG_LOAD:   rd_mux = 32'(ch_load[n]);
                     REG_VALUE:  rd_mux = 32'(ch_value[n]);
                     REG_CTRL:   rd_mux = {16'h0, ch_ctrl[n]};
                     REG_RIS:    rd_mux = {31'h0, ris[n]};
                     REG_MIS:    rd_mux = {31'h0, mis[n]};
                     REG_BGLOAD: rd_mux = 32'(ch_load[n]);
                     default:    rd_mux = 32'h0;
                  endcase
               end
            end
         end
         (PADDR == ADDR_INTSTAT): rd_mux = 32'(mis);
`ifdef CMSDK_MULTITIMER_ITEST_EN
         (PADDR == ADDR_ITCR):    rd_mux = {31'h0, itcr_q};
         (PADDR == ADDR_ITOP):    rd_mux = 32'(itop_q);
`endif
         id_hit: rd_mux = {24'h0, id_byte(PADDR[5:2], ECOREVNUM)};
         default: rd_mux = 32'h0;
      endcase
      prdata_d = setup_rd ? rd_mux : 32'h0;
   end

   // Registered read data.
   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET)
         prdata_q <= 32'h0;
      else
         prdata_q <= prdata_d;
   end

   assign PRDATA = prdata_q;

endmodule

// File: tb/tb_cmsdk_apb_multitimer.sv
// Self-checking bench for cmsdk_apb_multitimer: directed cases
// plus random APB traffic against a cycle reference model.
module tb_cmsdk_apb_multitimer;

   localparam int NCH = 2;

   logic           PCLK = 1'b0;
   logic           PRESET, PSEL, PENABLE, PWRITE;
   logic [11:2]    PADDR;
   logic [31:0]    PWDATA, PRDATA;
   logic [NCH-1:0] TIMCLKEN, TIMINT;
   logic [3:0]     ECOREVNUM;
   logic           TIMINTC;

   cmsdk_apb_multitimer #(.NUM_CH(NCH), .CNT_WIDTH(32)) dut (
      .PCLK      (PCLK),
      .PRESET    (PRESET),
      .PSEL      (PSEL),
      .PENABLE   (PENABLE),
      .PWRITE    (PWRITE),
      .PADDR     (PADDR),
      .PWDATA    (PWDATA),
      .TIMCLKEN  (TIMCLKEN),
      .ECOREVNUM (ECOREVNUM),
      .PRDATA    (PRDATA),
      .TIMINT    (TIMINT),
      .TIMINTC   (TIMINTC)
   );

   always #5 PCLK = ~PCLK;

   int errs = 0;
   int checks = 0;

   logic [31:0] m_load [NCH];
   logic [31:0] m_val  [NCH];
   logic [31:0] m_ctrl [NCH];
   logic [7:0]  m_pre  [NCH];
   logic        m_ris  [NCH];
   logic        m_zp   [NCH];
   logic        m_itcr;
   logic [NCH-1:0] m_itop;
   logic [31:0] m_prdata;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic m_reset();
      for (int c = 0; c < NCH; c++) begin
         m_load[c] = 0;
         m_val[c]  = 32'hFFFF_FFFF;
         m_ctrl[c] = 32'h40;
         m_pre[c]  = 0;
         m_ris[c]  = 0;
         m_zp[c]   = 0;
      end
      m_itcr = 0;
      m_itop = 0;
      m_prdata = 0;
   endtask

   function automatic logic [NCH-1:0] m_mis();
      logic [NCH-1:0] v;
      for (int c = 0; c < NCH; c++)
         v[c] = m_ris[c] & m_ctrl[c][6];
      return v;
   endfunction

   function automatic logic [NCH-1:0] m_timint();
`ifdef CMSDK_MULTITIMER_ITEST_EN
      if (m_itcr) return m_itop;
`endif
      return m_mis();
   endfunction

   function automatic logic [31:0] m_read(input logic [9:0] a);
      logic [11:0] ba;
      int c;
      ba = {a, 2'b00};
      if (ba < 12'h100) begin
         c = int'(ba[7:5]);
         if (c >= NCH) return 0;
         case (ba[4:0])
            5'h00, 5'h18: return m_load[c];
            5'h04: return m_val[c];
            5'h08: return m_ctrl[c];
            5'h10: return {31'h0, m_ris[c]};
            5'h14: return {31'h0, m_ris[c] & m_ctrl[c][6]};
            default: return 0;
         endcase
      end
      case (ba)
         12'h100: return 32'(m_mis());
`ifdef CMSDK_MULTITIMER_ITEST_EN
         12'hF00: return {31'h0, m_itcr};
         12'hF04: return 32'(m_itop);
`endif
         12'hFD0: return 32'h04;
         12'hFE0: return 32'h24;
         12'hFE4: return 32'hB8;
         12'hFE8: return 32'h1B;
         12'hFEC: return {24'h0, ECOREVNUM, 4'h0};
         12'hFF0: return 32'h0D;
         12'hFF4: return 32'hF0;
         12'hFF8: return 32'h05;
         12'hFFC: return 32'hB1;
         default: return 0;
      endcase
   endfunction

   // Advance the model by one clock using the inputs now applied.
   task automatic m_step();
      logic [31:0] nxt_prd;
      logic wr, prev_evt;
      logic [11:0] ba;
      ba = {PADDR, 2'b00};
      nxt_prd = (PSEL && !PWRITE && !PENABLE) ? m_read(PADDR) : 0;
      wr = PSEL && PWRITE && !PENABLE;
      prev_evt = 0;
      for (int c = 0; c < NCH; c++) begin
         logic hit, en, src, tick, evt;
         logic [4:0] off;
         off = ba[4:0];
         hit = wr && ba < 12'h100 && int'(ba[7:5]) == c;
         en = m_ctrl[c][7] && !(hit && off == 5'h08 && !PWDATA[7]);
         src = (c > 0 && m_ctrl[c][1]) ? prev_evt : TIMCLKEN[c];
         tick = 0;
         evt = 0;
         if (hit && off == 5'h00) begin
            m_load[c] = PWDATA;
            m_val[c]  = PWDATA;
            m_pre[c]  = 0;
            m_zp[c]   = (PWDATA == 0);
         end else begin
            if (hit && off == 5'h18) m_load[c] = PWDATA;
            if (src && en) begin
               if (m_pre[c] == 0) begin
                  tick = 1;
                  m_pre[c] = m_ctrl[c][15:8];
               end else
                  m_pre[c] = m_pre[c] - 1;
            end
            if (tick) begin
               evt = (m_val[c] == 1) || m_zp[c];
               m_zp[c] = 0;
               if (m_val[c] == 1) m_val[c] = 0;
               else if (m_val[c] == 0)
                  m_val[c] = m_ctrl[c][0] ? 0 :
                             m_ctrl[c][5] ? m_load[c] : 32'hFFFF_FFFF;
               else m_val[c] = m_val[c] - 1;
            end
         end
         if (hit && off == 5'h08) m_ctrl[c] = PWDATA & 32'hFFE3;
         if (evt) m_ris[c] = 1;
         else if (hit && off == 5'h0C) m_ris[c] = 0;
         prev_evt = evt;
      end
`ifdef CMSDK_MULTITIMER_ITEST_EN
      if (wr && ba == 12'hF00) m_itcr = PWDATA[0];
      if (wr && ba == 12'hF04) m_itop = PWDATA[NCH-1:0];
`endif
      m_prdata = nxt_prd;
   endtask

   task automatic cyc();
      m_step();
      @(posedge PCLK);
      @(negedge PCLK);
      chk("timint", 32'(TIMINT), 32'(m_timint()));
      chk("timintc", 32'(TIMINTC), 32'(|m_timint()));
      chk("prdata", PRDATA, m_prdata);
   endtask

   task automatic idle(input int n);
      PSEL = 0; PENABLE = 0; PWRITE = 0;
      for (int i = 0; i < n; i++) cyc();
   endtask

   task automatic apb_wr(input logic [11:0] a, input logic [31:0] d);
      PSEL = 1; PWRITE = 1; PENABLE = 0; PADDR = a[11:2]; PWDATA = d;
      cyc();
      PENABLE = 1;
      cyc();
      PSEL = 0; PENABLE = 0; PWRITE = 0;
   endtask

   task automatic apb_rd(input logic [11:0] a, output logic [31:0] d);
      PSEL = 1; PWRITE = 0; PENABLE = 0; PADDR = a[11:2];
      cyc();
      d = PRDATA;
      PENABLE = 1;
      cyc();
      PSEL = 0; PENABLE = 0;
   endtask

   // Setup phase with TIMCLKEN[0] high, access phase with it low.
   task automatic wr_on_tick(input logic [11:0] a, input logic [31:0] d);
      TIMCLKEN = 2'b01;
      PSEL = 1; PWRITE = 1; PENABLE = 0; PADDR = a[11:2]; PWDATA = d;
      cyc();
      TIMCLKEN = 2'b00;
      PENABLE = 1;
      cyc();
      PSEL = 0; PENABLE = 0; PWRITE = 0;
   endtask

   logic [31:0] rd;
   logic [11:0] ra;

   initial begin
      PSEL = 0; PENABLE = 0; PWRITE = 0; PADDR = '0; PWDATA = 0;
      TIMCLKEN = 0; ECOREVNUM = 4'h5;
      PRESET = 0;
      m_reset();
      #1 PRESET = 1;
      @(negedge PCLK);
      chk("rst_prdata", PRDATA, 0);
      chk("rst_timint", 32'(TIMINT), 0);
      @(negedge PCLK);
      PRESET = 0;

      apb_rd(12'h004, rd); chk("rst_value", rd, 32'hFFFF_FFFF);
      apb_rd(12'h008, rd); chk("rst_ctrl", rd, 32'h40);
      apb_rd(12'hFE0, rd); chk("pid0", rd, 32'h24);
      apb_rd(12'hFEC, rd); chk("pid3", rd, 32'h50);
      apb_rd(12'h800, rd); chk("unmapped", rd, 0);

      // Periodic ch0, load 4.
      apb_wr(12'h000, 4);
      apb_wr(12'h008, 32'hE0);
      TIMCLKEN = 2'b01;
      idle(3); chk("per_pre", 32'(TIMINT), 0);
      idle(1); chk("per_int", 32'(TIMINT), 1);
      idle(1);
      TIMCLKEN = 0;
      apb_rd(12'h004, rd); chk("per_reload", rd, 4);
      apb_wr(12'h00C, 0); chk("intclr", 32'(TIMINT), 0);

      // One-shot ch1, prescale 3, load 2.
      apb_wr(12'h020, 2);
      apb_wr(12'h028, 32'h3C1);
      TIMCLKEN = 2'b10;
      idle(4); chk("os_pre", 32'(TIMINT), 0);
      idle(1); chk("os_int", 32'(TIMINT), 2);
      apb_wr(12'h02C, 0);
      idle(20); chk("os_quiet", 32'(TIMINT), 0);
      TIMCLKEN = 0;
      apb_rd(12'h024, rd); chk("os_hold", rd, 0);

      // Chain: ch0 period 2 drives ch1 load 3.
      apb_wr(12'h000, 1);
      apb_wr(12'h008, 32'hA0);
      apb_wr(12'h020, 3);
      apb_wr(12'h028, 32'hE2);
      TIMCLKEN = 2'b01;
      idle(40);
      TIMCLKEN = 0;
      apb_rd(12'h100, rd); chk("intstat", rd, 32'(m_mis()));

      // Collisions.
      apb_wr(12'h028, 0);
      apb_wr(12'h02C, 0);
      apb_wr(12'h000, 1);
      apb_wr(12'h008, 32'hE0);
      apb_wr(12'h00C, 0);
      wr_on_tick(12'h00C, 0);
      chk("clr_vs_evt", 32'(TIMINT[0]), 1);
      wr_on_tick(12'h000, 9);
      apb_rd(12'h004, rd); chk("load_vs_tick", rd, 9);
      wr_on_tick(12'h008, 32'h60);
      apb_rd(12'h004, rd); chk("dis_vs_tick", rd, 9);

      // Random traffic.
      for (int it = 0; it < 400; it++) begin
         int op, c;
         TIMCLKEN = NCH'($urandom_range(0, 3));
         op = $urandom_range(0, 9);
         c = $urandom_range(0, NCH - 1);
         if (op <= 2) begin
            case ($urandom_range(0, 3))
               0: apb_wr(12'(c * 32 + 0), $urandom_range(0, 7));
               1: apb_wr(12'(c * 32 + 8),
                         ($urandom_range(0, 2) << 8)
                         | ($urandom & 32'hE3)
                         | (($urandom_range(0, 3) != 0) ? 32'h80 : 0));
               2: apb_wr(12'(c * 32 + 12), $urandom);
               default: apb_wr(12'(c * 32 + 24), $urandom_range(0, 7));
            endcase
         end else if (op <= 4) begin
            case ($urandom_range(0, 3))
               0: ra = 12'h100;
               1: ra = 12'hFC0 + 12'($urandom_range(0, 15) * 4);
               2: ra = 12'hF00;
               default: ra = 12'(c * 32 + $urandom_range(0, 7) * 4);
            endcase
            apb_rd(ra, rd);
         end else
            idle($urandom_range(1, 4));
      end

      // Asynchronous reset mid-count.
      apb_wr(12'h000, 3);
      apb_wr(12'h008, 32'hE0);
      TIMCLKEN = 2'b11;
      idle(3);
      PRESET = 1;
      #1;
      chk("mid_rst_timint", 32'(TIMINT), 0);
      chk("mid_rst_timintc", 32'(TIMINTC), 0);
      chk("mid_rst_prdata", PRDATA, 0);
      m_reset();
      @(negedge PCLK);
      PRESET = 0;
      TIMCLKEN = 0;
      apb_rd(12'h004, rd); chk("mid_rst_value", rd, 32'hFFFF_FFFF);
      apb_rd(12'h008, rd); chk("mid_rst_ctrl", rd, 32'h40);

      // Integration test registers.
      apb_wr(12'hF00, 1);
      apb_wr(12'hF04, 2);
`ifdef CMSDK_MULTITIMER_ITEST_EN
      chk("itop_timint", 32'(TIMINT), 2);
      chk("itop_timintc", 32'(TIMINTC), 1);
      apb_rd(12'hF00, rd); chk("itcr_rd", rd, 1);
`else
      chk("itop_timint", 32'(TIMINT), 0);
      apb_rd(12'hF00, rd); chk("itcr_rd", rd, 0);
`endif
      apb_wr(12'hF00, 0);
      idle(2);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
